// File: rtl/dcache_pkg.sv
// Shared widths, address field offsets, SRAM tag bit positions and FSM states
// for the 2-way, 16-set, 256-bit-line data-cache controller.
package dcache_pkg;

   localparam int LINE_W     = 256;
   localparam int TAG_W      = 23;
   localparam int IDX_W      = 4;
   localparam int OFF_W      = 3;
   localparam int TAG_LSB    = 9;
   localparam int IDX_LSB    = 5;
   localparam int OFF_LSB    = 2;
   localparam int SRAM_TAG_W = TAG_W + 2;
   localparam int VALID_BIT  = SRAM_TAG_W - 1;
   localparam int DIRTY_BIT  = SRAM_TAG_W - 2;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WB   = 2'd1,
      ST_RD   = 2'd2,
      ST_FILL = 2'd3
   } state_e;

   // SRAM tag field is {valid, dirty, tag}; everything written is valid.
   function automatic logic [SRAM_TAG_W-1:0] make_tag(input logic dirty,
                                                      input logic [TAG_W-1:0] tag);
      return {1'b1, dirty, tag};
   endfunction

endpackage

// File: rtl/dcache_word_merge.sv
// Combinational 32-bit word select and word replace on a cache line,
// indexed by the 3-bit word offset of the byte address.
module dcache_word_merge
   import dcache_pkg::*;
(
   input  logic [LINE_W-1:0] line_i,
   input  logic [OFF_W-1:0]  off_i,
   input  logic [31:0]       data_i,
   output logic [31:0]       word_o,
   output logic [LINE_W-1:0] line_o
);

   always_comb begin
      word_o = line_i[{off_i, 5'b0} +: 32];
      line_o = line_i;
      line_o[{off_i, 5'b0} +: 32] = data_i;
   end

endmodule

// File: rtl/dcache_ctrl.sv
// Data-cache controller: hit path against the cache SRAM, write-back/line-fill
// against main memory. Define DCACHE_CTRL_PERF_CNT_EN to add hit/miss counters.
module dcache_ctrl
   import dcache_pkg::*;
(
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  cpu_req_i,
   input  logic                  cpu_we_i,
   input  logic [31:0]           cpu_addr_i,
   input  logic [31:0]           cpu_data_i,
   output logic [31:0]           cpu_data_o,
   output logic                  stall_o,
   output logic [IDX_W-1:0]      sram_addr_o,
   output logic [SRAM_TAG_W-1:0] sram_tag_o,
   output logic [LINE_W-1:0]     sram_data_o,
   output logic                  sram_enable_o,
   output logic                  sram_write_o,
   input  logic [SRAM_TAG_W-1:0] sram_tag_i,
   input  logic [LINE_W-1:0]     sram_data_i,
   input  logic                  sram_hit_i,
   output logic                  mem_enable_o,
   output logic                  mem_write_o,
   output logic [31:0]           mem_addr_o,
   output logic [LINE_W-1:0]     mem_data_o,
   input  logic [LINE_W-1:0]     mem_data_i,
   input  logic                  mem_ack_i
`ifdef DCACHE_CTRL_PERF_CNT_EN
  ,output logic [31:0]           hit_cnt_o,
   output logic [31:0]           miss_cnt_o
`endif
);

   logic [TAG_W-1:0]  cpu_tag;
   logic [IDX_W-1:0]  cpu_idx;
   logic [OFF_W-1:0]  cpu_off;
   logic [31:0]       hit_word;
   logic [LINE_W-1:0] merged_line;
   logic              victim_dirty;
   logic              unused_addr;

   state_e            state_q, state_d;
   logic              mem_enable_q, mem_enable_d;
   logic              mem_write_q, mem_write_d;
   logic [31:0]       mem_addr_q, mem_addr_d;
   logic [LINE_W-1:0] mem_data_q, mem_data_d;
   logic [LINE_W-1:0] fill_q, fill_d;
   logic [TAG_W-1:0]  req_tag_q, req_tag_d;
   logic [IDX_W-1:0]  req_idx_q, req_idx_d;
`ifdef DCACHE_CTRL_PERF_CNT_EN
   logic [31:0]       hit_cnt_q, hit_cnt_d;
   logic [31:0]       miss_cnt_q, miss_cnt_d;
`endif

   assign cpu_tag      = cpu_addr_i[TAG_LSB +: TAG_W];
   assign cpu_idx      = cpu_addr_i[IDX_LSB +: IDX_W];
   assign cpu_off      = cpu_addr_i[OFF_LSB +: OFF_W];
   assign unused_addr  = ^cpu_addr_i[1:0];
   assign victim_dirty = sram_tag_i[VALID_BIT] & sram_tag_i[DIRTY_BIT];

   dcache_word_merge u_merge (
      .line_i (sram_data_i),
      .off_i  (cpu_off),
      .data_i (cpu_data_i),
      .word_o (hit_word),
      .line_o (merged_line)
   );

   always_comb begin
      state_d       = state_q;
      mem_enable_d  = mem_enable_q;
      mem_write_d   = mem_write_q;
      mem_addr_d    = mem_addr_q;
      mem_data_d    = mem_data_q;
      fill_d        = fill_q;
      req_tag_d     = req_tag_q;
      req_idx_d     = req_idx_q;
      cpu_data_o    = '0;
      stall_o       = 1'b0;
      sram_addr_o   = '0;
      sram_tag_o    = '0;
      sram_data_o   = '0;
      sram_enable_o = 1'b0;
      sram_write_o  = 1'b0;
`ifdef DCACHE_CTRL_PERF_CNT_EN
      hit_cnt_d     = hit_cnt_q;
      miss_cnt_d    = miss_cnt_q;
`endif
      unique case (state_q)
         ST_IDLE: begin
            if (cpu_req_i) begin
               sram_enable_o = 1'b1;
               sram_addr_o   = cpu_idx;
               sram_tag_o    = make_tag(1'b0, cpu_tag);
               if (sram_hit_i) begin
                  cpu_data_o = hit_word;
                  if (cpu_we_i) begin
                     sram_write_o = 1'b1;
                     sram_data_o  = merged_line;
                     sram_tag_o   = make_tag(1'b1, cpu_tag);
                  end
`ifdef DCACHE_CTRL_PERF_CNT_EN
                  if (hit_cnt_q != '1) hit_cnt_d = hit_cnt_q + 32'd1;
`endif
               end else begin
                  // Remember the missing line so the fill survives a dropped request.
                  stall_o      = 1'b1;
                  req_tag_d    = cpu_tag;
                  req_idx_d    = cpu_idx;
                  mem_enable_d = 1'b1;
`ifdef DCACHE_CTRL_PERF_CNT_EN
                  if (miss_cnt_q != '1) miss_cnt_d = miss_cnt_q + 32'd1;
`endif
                  if (victim_dirty) begin
                     state_d     = ST_WB;
                     mem_write_d = 1'b1;
                     mem_addr_d  = {sram_tag_i[TAG_W-1:0], cpu_idx, 5'b0};
                     mem_data_d  = sram_data_i;
                  end else begin
                     state_d     = ST_RD;
                     mem_write_d = 1'b0;
                     mem_addr_d  = {cpu_tag, cpu_idx, 5'b0};
                  end
               end
            end
         end
         ST_WB: begin
            stall_o = 1'b1;
            if (mem_ack_i) begin
               state_d     = ST_RD;
               mem_write_d = 1'b0;
               mem_addr_d  = {req_tag_q, req_idx_q, 5'b0};
            end
         end
         ST_RD: begin
            stall_o = 1'b1;
            if (mem_ack_i) begin
               state_d      = ST_FILL;
               mem_enable_d = 1'b0;
               fill_d       = mem_data_i;
            end
         end
         ST_FILL: begin
            stall_o       = 1'b1;
            sram_enable_o = 1'b1;
            sram_write_o  = 1'b1;
            sram_addr_o   = req_idx_q;
            sram_tag_o    = make_tag(1'b0, req_tag_q);
            sram_data_o   = fill_q;
            state_d       = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state_q      <= ST_IDLE;
         mem_enable_q <= 1'b0;
         mem_write_q  <= 1'b0;
         mem_addr_q   <= '0;
         mem_data_q   <= '0;
         fill_q       <= '0;
         req_tag_q    <= '0;
         req_idx_q    <= '0;
`ifdef DCACHE_CTRL_PERF_CNT_EN
         hit_cnt_q    <= '0;
         miss_cnt_q   <= '0;
`endif
      end else begin
         state_q      <= state_d;
         mem_enable_q <= mem_enable_d;
         mem_write_q  <= mem_write_d;
         mem_addr_q   <= mem_addr_d;
         mem_data_q   <= mem_data_d;
         fill_q       <= fill_d;
         req_tag_q    <= req_tag_d;
         req_idx_q    <= req_idx_d;
`ifdef DCACHE_CTRL_PERF_CNT_EN
         hit_cnt_q    <= hit_cnt_d;
         miss_cnt_q   <= miss_cnt_d;
`endif
      end
   end

   assign mem_enable_o = mem_enable_q;
   assign mem_write_o  = mem_write_q;
   assign mem_addr_o   = mem_addr_q;
   assign mem_data_o   = mem_data_q;
`ifdef DCACHE_CTRL_PERF_CNT_EN
   assign hit_cnt_o    = hit_cnt_q;
   assign miss_cnt_o   = miss_cnt_q;
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl: the bench plays both the cache SRAM and main
// memory, and checks hits, clean/dirty misses, ack timing and mid-miss reset.
module tb_dcache_ctrl;

   logic         clk_i = 1'b0;
   logic         rst_i = 1'b0;
   logic         cpu_req_i = 1'b0;
   logic         cpu_we_i = 1'b0;
   logic [31:0]  cpu_addr_i = '0;
   logic [31:0]  cpu_data_i = '0;
   logic [31:0]  cpu_data_o;
   logic         stall_o;
   logic [3:0]   sram_addr_o;
   logic [24:0]  sram_tag_o;
   logic [255:0] sram_data_o;
   logic         sram_enable_o;
   logic         sram_write_o;
   logic [24:0]  sram_tag_i = '0;
   logic [255:0] sram_data_i = '0;
   logic         sram_hit_i = 1'b0;
   logic         mem_enable_o;
   logic         mem_write_o;
   logic [31:0]  mem_addr_o;
   logic [255:0] mem_data_o;
   logic [255:0] mem_data_i = '0;
   logic         mem_ack_i = 1'b0;
`ifdef DCACHE_CTRL_PERF_CNT_EN
   logic [31:0]  hit_cnt_o;
   logic [31:0]  miss_cnt_o;
`endif

   int checks = 0;
   int failures = 0;
   int stallCycles = 0;

   logic [255:0] fillLine, storeLine, victimLine, fill2Line, fill3Line;

   dcache_ctrl dut (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .cpu_req_i     (cpu_req_i),
      .cpu_we_i      (cpu_we_i),
      .cpu_addr_i    (cpu_addr_i),
      .cpu_data_i    (cpu_data_i),
      .cpu_data_o    (cpu_data_o),
      .stall_o       (stall_o),
      .sram_addr_o   (sram_addr_o),
      .sram_tag_o    (sram_tag_o),
      .sram_data_o   (sram_data_o),
      .sram_enable_o (sram_enable_o),
      .sram_write_o  (sram_write_o),
      .sram_tag_i    (sram_tag_i),
      .sram_data_i   (sram_data_i),
      .sram_hit_i    (sram_hit_i),
      .mem_enable_o  (mem_enable_o),
      .mem_write_o   (mem_write_o),
      .mem_addr_o    (mem_addr_o),
      .mem_data_o    (mem_data_o),
      .mem_data_i    (mem_data_i),
      .mem_ack_i     (mem_ack_i)
`ifdef DCACHE_CTRL_PERF_CNT_EN
     ,.hit_cnt_o     (hit_cnt_o),
      .miss_cnt_o    (miss_cnt_o)
`endif
   );

   // 10 ns clock; the DUT samples on the rising edge.
   always #5 clk_i = ~clk_i;

   // Drive one cycle's inputs just after the falling edge, let combinational
   // outputs settle, and accumulate stall cycles for latency checks.
   task automatic applyStimulus(input logic req, input logic we, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic hit,
                                input logic [24:0] stag, input logic [255:0] sdata,
                                input logic [255:0] mdata, input logic ack);
      @(negedge clk_i);
      cpu_req_i   = req;
      cpu_we_i    = we;
      cpu_addr_i  = addr;
      cpu_data_i  = wdata;
      sram_hit_i  = hit;
      sram_tag_i  = stag;
      sram_data_i = sdata;
      mem_data_i  = mdata;
      mem_ack_i   = ack;
      #1;
      if (stall_o === 1'b1) stallCycles++;
   endtask

   task automatic checkOutput(input string tag, input logic [255:0] observed,
                              input logic [255:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         failures++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // Directed sequence; every expected value below is worked out by hand.
   initial begin
      for (int i = 0; i < 8; i++) begin
         fillLine[32*i +: 32]   = 32'h1000_0000 + i;
         victimLine[32*i +: 32] = 32'hA000_0000 + i;
         fill2Line[32*i +: 32]  = 32'h2000_0000 + i;
         fill3Line[32*i +: 32]  = 32'h3000_0000 + i;
      end
      fillLine[63:32] = 32'hDEADBEEF;
      storeLine = fillLine;
      storeLine[95:64] = 32'h1234_5678;

      $display("[TB] reset");
      rst_i = 1'b0;
      applyStimulus(0, 0, 32'h0, 32'h0, 0, '0, '0, '0, 0);
      applyStimulus(0, 0, 32'h0, 32'h0, 0, '0, '0, '0, 0);
      checkOutput("rst_mem_enable", mem_enable_o, 1'b0);
      checkOutput("rst_mem_write", mem_write_o, 1'b0);
      checkOutput("rst_mem_addr", mem_addr_o, 32'h0);
      checkOutput("rst_mem_data", mem_data_o, 256'h0);
      checkOutput("rst_stall", stall_o, 1'b0);
      checkOutput("rst_sram_enable", sram_enable_o, 1'b0);
      checkOutput("rst_cpu_data", cpu_data_o, 32'h0);
      rst_i = 1'b1;

      $display("[TB] cold load miss 0x44");
      stallCycles = 0;
      applyStimulus(1, 0, 32'h44, 32'h0, 0, 25'h0, '0, '0, 0);
      checkOutput("cold_idle_stall", stall_o, 1'b1);
      checkOutput("cold_lookup_en", sram_enable_o, 1'b1);
      checkOutput("cold_lookup_tag", sram_tag_o, 25'h100_0000);
      checkOutput("cold_lookup_idx", sram_addr_o, 4'd2);
      applyStimulus(1, 0, 32'h44, 32'h0, 0, 25'h0, '0, '0, 0);
      checkOutput("cold_rd_enable", mem_enable_o, 1'b1);
      checkOutput("cold_rd_write", mem_write_o, 1'b0);
      checkOutput("cold_rd_addr", mem_addr_o, 32'h40);
      applyStimulus(1, 0, 32'h44, 32'h0, 0, 25'h0, '0, '0, 0);
      applyStimulus(1, 0, 32'h44, 32'h0, 0, 25'h0, '0, fillLine, 1);
      checkOutput("cold_rd_held", mem_enable_o, 1'b1);
      applyStimulus(1, 0, 32'h44, 32'h0, 0, 25'h0, '0, '0, 0);
      checkOutput("cold_fill_write", sram_write_o, 1'b1);
      checkOutput("cold_fill_data", sram_data_o, fillLine);
      checkOutput("cold_fill_tag", sram_tag_o, 25'h100_0000);
      checkOutput("cold_fill_idx", sram_addr_o, 4'd2);
      checkOutput("cold_fill_mem_off", mem_enable_o, 1'b0);
      applyStimulus(1, 0, 32'h44, 32'h0, 1, 25'h100_0000, fillLine, '0, 0);
      checkOutput("cold_retry_stall", stall_o, 1'b0);
      checkOutput("cold_retry_data", cpu_data_o, 32'hDEADBEEF);
      checkOutput("cold_stall_cycles", stallCycles, 5);

      $display("[TB] store hit 0x48");
      applyStimulus(1, 1, 32'h48, 32'h1234_5678, 1, 25'h100_0000, fillLine, '0, 0);
      checkOutput("store_stall", stall_o, 1'b0);
      checkOutput("store_write", sram_write_o, 1'b1);
      checkOutput("store_tag", sram_tag_o, 25'h180_0000);
      checkOutput("store_line", sram_data_o, storeLine);

      $display("[TB] dirty eviction tag3 idx2, request dropped during RD");
      stallCycles = 0;
      applyStimulus(1, 0, 32'h640, 32'h0, 0, 25'h180_0001, victimLine, '0, 0);
      checkOutput("dirty_idle_stall", stall_o, 1'b1);
      checkOutput("dirty_lookup_tag", sram_tag_o, 25'h100_0003);
      applyStimulus(1, 0, 32'h640, 32'h0, 0, 25'h0, '0, '0, 0);
      checkOutput("wb_enable", mem_enable_o, 1'b1);
      checkOutput("wb_write", mem_write_o, 1'b1);
      checkOutput("wb_addr", mem_addr_o, 32'h240);
      checkOutput("wb_data", mem_data_o, victimLine);
      applyStimulus(1, 0, 32'h640, 32'h0, 0, 25'h0, '0, '0, 1);
      checkOutput("wb_held_stall", stall_o, 1'b1);
      applyStimulus(0, 0, 32'h0, 32'h0, 0, 25'h0, '0, fill2Line, 1);
      checkOutput("rd_after_wb_write", mem_write_o, 1'b0);
      checkOutput("rd_after_wb_addr", mem_addr_o, 32'h640);
      checkOutput("rd_after_wb_enable", mem_enable_o, 1'b1);
      applyStimulus(0, 0, 32'h0, 32'h0, 0, 25'h0, '0, '0, 0);
      checkOutput("dirty_fill_write", sram_write_o, 1'b1);
      checkOutput("dirty_fill_data", sram_data_o, fill2Line);
      checkOutput("dirty_fill_tag", sram_tag_o, 25'h100_0003);
      checkOutput("dirty_fill_idx", sram_addr_o, 4'd2);
      checkOutput("dirty_fill_mem_off", mem_enable_o, 1'b0);
      applyStimulus(0, 0, 32'h0, 32'h0, 0, 25'h0, '0, '0, 0);
      checkOutput("dropped_idle_stall", stall_o, 1'b0);
      checkOutput("dropped_idle_sram", sram_enable_o, 1'b0);
      checkOutput("dirty_stall_cycles", stallCycles, 5);
      applyStimulus(1, 0, 32'h640, 32'h0, 1, 25'h100_0003, fill2Line, '0, 0);
      checkOutput("dirty_retry_data", cpu_data_o, 32'h2000_0000);

      $display("[TB] reset during RD");
      applyStimulus(1, 0, 32'h2000_0000, 32'h0, 0, 25'h0, '0, '0, 0);
      applyStimulus(1, 0, 32'h2000_0000, 32'h0, 0, 25'h0, '0, '0, 0);
      checkOutput("rd_before_reset", mem_enable_o, 1'b1);
      rst_i = 1'b0;
      applyStimulus(0, 0, 32'h0, 32'h0, 0, 25'h0, '0, '0, 0);
      checkOutput("reset_rd_mem_off", mem_enable_o, 1'b0);
      checkOutput("reset_rd_stall", stall_o, 1'b0);
      rst_i = 1'b1;

      $display("[TB] stray ack in IDLE, then single-cycle clean miss");
      applyStimulus(0, 0, 32'h0, 32'h0, 0, 25'h0, '0, fill3Line, 1);
      applyStimulus(0, 0, 32'h0, 32'h0, 0, 25'h0, '0, '0, 0);
      checkOutput("stray_ack_stall", stall_o, 1'b0);
      checkOutput("stray_ack_mem", mem_enable_o, 1'b0);
      stallCycles = 0;
      applyStimulus(1, 0, 32'h100, 32'h0, 0, 25'h0, '0, '0, 0);
      applyStimulus(1, 0, 32'h100, 32'h0, 0, 25'h0, '0, fill3Line, 1);
      checkOutput("fast_rd_addr", mem_addr_o, 32'h100);
      applyStimulus(1, 0, 32'h100, 32'h0, 0, 25'h0, '0, '0, 0);
      checkOutput("fast_fill_data", sram_data_o, fill3Line);
      checkOutput("fast_fill_idx", sram_addr_o, 4'd8);
      applyStimulus(1, 0, 32'h100, 32'h0, 1, 25'h100_0000, fill3Line, '0, 0);
      checkOutput("fast_retry_data", cpu_data_o, 32'h3000_0000);
      checkOutput("fast_stall_cycles", stallCycles, 3);
      applyStimulus(1, 0, 32'h10C, 32'h0, 1, 25'h100_0000, fill3Line, '0, 0);
      checkOutput("hit_word3", cpu_data_o, 32'h3000_0003);
      applyStimulus(1, 0, 32'h11C, 32'h0, 1, 25'h100_0000, fill3Line, '0, 0);
      checkOutput("hit_word7", cpu_data_o, 32'h3000_0007);
      applyStimulus(1, 0, 32'h108, 32'h0, 1, 25'h100_0000, fill3Line, '0, 0);
      checkOutput("hit_word2", cpu_data_o, 32'h3000_0002);
      applyStimulus(0, 0, 32'h0, 32'h0, 0, 25'h0, '0, '0, 0);
      checkOutput("idle_cpu_data", cpu_data_o, 32'h0);
`ifdef DCACHE_CTRL_PERF_CNT_EN
      checkOutput("miss_cnt", miss_cnt_o, 32'd1);
      checkOutput("hit_cnt", hit_cnt_o, 32'd4);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
